udp_rx: RTL and testbench

UDP_RX -- requirements
Module: udp_rx

---
 rtl/udp_rx_pkg.sv | 22 ++
 rtl/rx_word_pack.sv | 61 ++++++
 rtl/udp_rx.sv | 158 +++++++++++++++
 tb/tb_udp_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive path: parser states and the fixed
// protocol constants the parser matches against.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    IP_HEAD,
    UDP_HEAD,
    RX_DATA,
    RX_END
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam int          ETH_HEAD_LEN  = 14;
  localparam int          UDP_HEAD_LEN  = 8;

endpackage

// File: rtl/rx_word_pack.sv
// Packs payload bytes big-endian into 32-bit words. A word is emitted after
// its 4th byte, or early when 'last' marks the final byte (left-aligned,
// unused low bytes zero). 'clr' drops any partially collected word.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clr                discard partial word
//   byte_vld, last     payload byte strobe / this byte ends the payload
//   data_byte          payload byte
//   word_en, word      registered one-cycle strobe and held packed word
module rx_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic        last,
  input  logic [7:0]  data_byte,
  output logic        word_en,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    case (idx)
      2'd0: acc_nxt[31:24] = data_byte;
      2'd1: acc_nxt[23:16] = data_byte;
      2'd2: acc_nxt[15:8]  = data_byte;
      default: acc_nxt[7:0] = data_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      acc     <= '0;
      word    <= '0;
      word_en <= 1'b0;
    end else begin
      word_en <= 1'b0;
      if (clr) begin
        idx <= '0;
        acc <= '0;
      end else if (byte_vld) begin
        if (idx == 2'd3 || last) begin
          // acc is cleared after every emit so a short final word is zero-filled
          word    <= acc_nxt;
          word_en <= 1'b1;
          acc     <= '0;
          idx     <= '0;
        end else begin
          acc <= acc_nxt;
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_rx.sv
// GMII UDP receiver: strips preamble, Ethernet, IPv4 and UDP headers,
// filters on destination MAC (unicast or broadcast), EtherType, IP version,
// protocol and destination IP, and delivers the payload as 32-bit words.
// Ports:
//   clk, rst_n               GMII rx clock, async active-low reset
//   gmii_rx_dv, gmii_rxd     receive data valid and byte
//   rec_en, rec_data         payload word strobe and held word
//   rec_pkt_done             strobe with the final word of an accepted packet
//   rec_byte_num             payload length of the last completed packet
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num
);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] data_len;
  logic [5:0]  ip_hlen;
  logic [39:0] da;

  logic [47:0] mac;
  logic [15:0] udp_len;
  logic [7:0]  ip_exp;
  logic        byte_vld;
  logic        last_byte;

  // First five destination MAC bytes are shifted in; the sixth is live.
  assign mac       = {da, gmii_rxd};
  // UDP length high byte is parked in data_len[7:0] until the low byte arrives.
  assign udp_len   = {data_len[7:0], gmii_rxd};
  assign byte_vld  = (state == RX_DATA) && gmii_rx_dv;
  assign last_byte = (cnt == data_len - 16'd1);

  always_comb begin
    case (cnt[1:0])
      2'd0:    ip_exp = BOARD_IP[31:24];
      2'd1:    ip_exp = BOARD_IP[23:16];
      2'd2:    ip_exp = BOARD_IP[15:8];
      default: ip_exp = BOARD_IP[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      data_len     <= '0;
      ip_hlen      <= '0;
      da           <= '0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= '0;
    end else begin
      rec_pkt_done <= 1'b0;
      if (!gmii_rx_dv) begin
        // dv low aborts any frame in progress and ends RX_END
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (gmii_rxd == PREAMBLE_BYTE) state <= PREAMBLE;
          end
          PREAMBLE: begin
            if (gmii_rxd == PREAMBLE_BYTE && cnt < 16'd6) begin
              cnt <= cnt + 16'd1;
            end else if (gmii_rxd == SFD_BYTE && cnt == 16'd6) begin
              state <= ETH_HEAD;
              cnt   <= '0;
            end else begin
              state <= RX_END;
            end
          end
          ETH_HEAD: begin
            cnt <= cnt + 16'd1;
            if (cnt < 16'd5) da <= {da[31:0], gmii_rxd};
            if (cnt == 16'd5 && mac != BOARD_MAC && mac != 48'hFFFF_FFFF_FFFF)
              state <= RX_END;
            else if (cnt == 16'd12 && gmii_rxd != ETH_TYPE_IP[15:8])
              state <= RX_END;
            else if (cnt == 16'(ETH_HEAD_LEN - 1)) begin
              cnt <= '0;
              if (gmii_rxd != ETH_TYPE_IP[7:0]) state <= RX_END;
              else                              state <= IP_HEAD;
            end
          end
          IP_HEAD: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd0) begin
              ip_hlen <= {gmii_rxd[3:0], 2'b00};
              // IHL below 5 cannot hold the fields checked below
              if (gmii_rxd[7:4] != 4'd4 || gmii_rxd[3:0] < 4'd5) state <= RX_END;
            end else if (cnt == 16'd9 && gmii_rxd != IP_PROTO_UDP) begin
              state <= RX_END;
            end else if (cnt >= 16'd16 && cnt <= 16'd19 && gmii_rxd != ip_exp) begin
              state <= RX_END;
            end else if (cnt == {10'd0, ip_hlen} - 16'd1) begin
              state <= UDP_HEAD;
              cnt   <= '0;
            end
          end
          UDP_HEAD: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd4) begin
              data_len <= {8'd0, gmii_rxd};
            end else if (cnt == 16'd5) begin
              if (udp_len < 16'(UDP_HEAD_LEN)) state <= RX_END;
              else data_len <= udp_len - 16'(UDP_HEAD_LEN);
            end else if (cnt == 16'(UDP_HEAD_LEN - 1)) begin
              cnt <= '0;
              if (data_len == 16'd0) begin
                rec_pkt_done <= 1'b1;
                rec_byte_num <= '0;
                state        <= RX_END;
              end else begin
                state <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            cnt <= cnt + 16'd1;
            if (last_byte) begin
              // lines up with the packer's final word strobe
              rec_pkt_done <= 1'b1;
              rec_byte_num <= data_len;
              state        <= RX_END;
            end
          end
          RX_END: state <= RX_END;
          default: state <= IDLE;
        endcase
      end
    end
  end

  rx_word_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!gmii_rx_dv),
    .byte_vld  (byte_vld),
    .last      (last_byte),
    .data_byte (gmii_rxd),
    .word_en   (rec_en),
    .word      (rec_data)
  );

endmodule

// File: tb/tb_udp_rx.sv
module tb_udp_rx;
  import udp_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;

  always #4 clk = ~clk;

  udp_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num)
  );

  typedef struct {
    logic [47:0] mac;
    logic [15:0] etype;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [7:0]  proto;
    logic [31:0] ip;
    logic [15:0] ulen;
    int          pl_n;
    logic [79:0] pl;
    int          pad;
    int          nw;
    logic [95:0] ew;
    int          ndone;
    logic [15:0] bn;
  } vec_t;

  localparam logic [47:0] MAC_OK = 48'h00_11_22_33_44_55;
  localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] IP_OK  = 32'hC0_A8_01_0A;

  vec_t       vecs[$];
  logic [7:0] fq[$];
  int         errors = 0;
  int         checks = 0;

  logic [31:0] got_w[$];
  int          got_done = 0;
  logic        done_with_en = 1'b0;

  always @(negedge clk) begin
    if (rec_en) got_w.push_back(rec_data);
    if (rec_pkt_done) begin
      got_done     = got_done + 1;
      done_with_en = rec_en;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [47:0] mac, input logic [15:0] etype, input logic [3:0] ver,
                     input logic [3:0] ihl, input logic [7:0] proto, input logic [31:0] ip,
                     input logic [15:0] ulen, input int pl_n, input logic [79:0] pl,
                     input int pad, input int nw, input logic [95:0] ew,
                     input int ndone, input logic [15:0] bn);
    vec_t v;
    v.mac = mac; v.etype = etype; v.ver = ver; v.ihl = ihl; v.proto = proto;
    v.ip = ip; v.ulen = ulen; v.pl_n = pl_n; v.pl = pl; v.pad = pad;
    v.nw = nw; v.ew = ew; v.ndone = ndone; v.bn = bn;
    vecs.push_back(v);
  endtask

  task automatic build(input vec_t v);
    logic [15:0] tot;
    logic [79:0] t;
    fq.delete();
    for (int i = 0; i < 7; i++) fq.push_back(8'h55);
    fq.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fq.push_back(v.mac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fq.push_back(8'h02);
    fq.push_back(v.etype[15:8]); fq.push_back(v.etype[7:0]);
    tot = {10'd0, v.ihl, 2'b00} + v.ulen;
    fq.push_back({v.ver, v.ihl}); fq.push_back(8'h00);
    fq.push_back(tot[15:8]); fq.push_back(tot[7:0]);
    for (int i = 0; i < 4; i++) fq.push_back(8'h00);
    fq.push_back(8'd64); fq.push_back(v.proto);
    fq.push_back(8'h00); fq.push_back(8'h00);
    fq.push_back(8'hC0); fq.push_back(8'hA8); fq.push_back(8'h01); fq.push_back(8'h02);
    for (int i = 0; i < 4; i++) fq.push_back(v.ip[31-8*i -: 8]);
    for (int i = 20; i < 4 * int'(v.ihl); i++) fq.push_back(8'h00);
    fq.push_back(8'h04); fq.push_back(8'hD2); fq.push_back(8'h04); fq.push_back(8'hD2);
    fq.push_back(v.ulen[15:8]); fq.push_back(v.ulen[7:0]);
    fq.push_back(8'h00); fq.push_back(8'h00);
    for (int i = 0; i < v.pl_n; i++) begin
      t = v.pl >> (72 - 8 * i);
      fq.push_back(t[7:0]);
    end
    for (int i = 0; i < v.pad; i++) fq.push_back(8'h00);
    fq.push_back(8'hDE); fq.push_back(8'hAD); fq.push_back(8'hBE); fq.push_back(8'hEF);
  endtask

  task automatic drive(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fq[i];
      @(posedge clk); #1;
    end
    if (gap) begin
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_got();
    got_w.delete();
    got_done     = 0;
    done_with_en = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [95:0] ew;
    logic [31:0] gw;

    //  mac     etype     ver ihl proto  ip            ulen  n  payload                       pad nw expected words                            nd bn
    add(MAC_OK, 16'h0800, 4, 5, 8'd17, IP_OK,        16,  8, 80'h01020304050607080000,  0, 2, 96'h01020304_05060708_00000000, 1, 16'd8);
    add(MAC_BC, 16'h0800, 4, 5, 8'd17, IP_OK,        13,  5, 80'hAABBCCDDEE0000000000,  4, 2, 96'hAABBCCDD_EE000000_00000000, 1, 16'd5);
    add(MAC_OK, 16'h0800, 4, 5, 8'd17, 32'hC0A8010B, 16,  8, 80'h01020304050607080000,  0, 0, 96'h0,                          0, 16'd5);
    add(MAC_OK, 16'h0800, 4, 5, 8'd6,  IP_OK,        16,  8, 80'h01020304050607080000,  0, 0, 96'h0,                          0, 16'd5);
    add(MAC_OK, 16'h0800, 4, 6, 8'd17, IP_OK,        12,  4, 80'h11223344000000000000,  2, 1, 96'h11223344_00000000_00000000, 1, 16'd4);
    add(48'h001122334456, 16'h0800, 4, 5, 8'd17, IP_OK, 16, 8, 80'h01020304050607080000, 0, 0, 96'h0,                      0, 16'd4);
    add(MAC_OK, 16'h0806, 4, 5, 8'd17, IP_OK,        16,  8, 80'h01020304050607080000,  0, 0, 96'h0,                          0, 16'd4);
    add(MAC_OK, 16'h0800, 6, 5, 8'd17, IP_OK,        16,  8, 80'h01020304050607080000,  0, 0, 96'h0,                          0, 16'd4);
    add(MAC_OK, 16'h0800, 4, 5, 8'd17, IP_OK,         7,  4, 80'h01020304000000000000,  0, 0, 96'h0,                          0, 16'd4);
    add(MAC_OK, 16'h0800, 4, 5, 8'd17, IP_OK,         8,  0, 80'h0,                     6, 0, 96'h0,                          1, 16'd0);
    add(MAC_OK, 16'h0800, 4, 5, 8'd17, IP_OK,        11,  3, 80'h01020300000000000000,  5, 1, 96'h01020300_00000000_00000000, 1, 16'd3);
    add(MAC_OK, 16'h0800, 4, 5, 8'd17, IP_OK,        18, 10, 80'h0102030405060708090A,  0, 3, 96'h01020304_05060708_090A0000, 1, 16'd10);

    repeat (3) @(posedge clk);
    #1;
    chk("reset rec_en", 32'(rec_en), 32'd0);
    chk("reset rec_pkt_done", 32'(rec_pkt_done), 32'd0);
    chk("reset rec_data", rec_data, 32'd0);
    chk("reset rec_byte_num", 32'(rec_byte_num), 32'd0);
    chk("reset state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // frames back to back with a single dv-low cycle between them
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      clear_got();
      build(v);
      drive(fq.size(), 1'b1);
      chk($sformatf("v%0d nwords", k), got_w.size(), v.nw);
      for (int w = 0; w < v.nw; w++) begin
        ew = v.ew << (32 * w);
        gw = (w < got_w.size()) ? got_w[w] : 32'hxxxxxxxx;
        chk($sformatf("v%0d word%0d", k, w), gw, ew[95:64]);
      end
      chk($sformatf("v%0d done", k), got_done, v.ndone);
      if (v.ndone > 0) chk($sformatf("v%0d done_with_en", k), 32'(done_with_en), 32'(v.nw > 0));
      chk($sformatf("v%0d byte_num", k), 32'(rec_byte_num), 32'(v.bn));
      if (v.nw > 0) begin
        ew = v.ew << (32 * (v.nw - 1));
        chk($sformatf("v%0d data_hold", k), rec_data, ew[95:64]);
      end
    end

    // dv drops after 6 of 10 payload bytes
    clear_got();
    build(vecs[11]);
    drive(56, 1'b0);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    @(posedge clk); #1;
    chk("abort state", 32'(dut.state), 32'(IDLE));
    repeat (4) @(posedge clk);
    #1;
    chk("abort nwords", got_w.size(), 1);
    gw = (got_w.size() > 0) ? got_w[0] : 32'hxxxxxxxx;
    chk("abort word0", gw, 32'h01020304);
    chk("abort done", got_done, 0);
    chk("abort byte_num", 32'(rec_byte_num), 32'd10);

    // reset pulse while in the IP header
    clear_got();
    build(vecs[0]);
    drive(27, 1'b0);
    chk("pre-reset state", 32'(dut.state), 32'(IP_HEAD));
    gmii_rx_dv = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("midrst rec_en", 32'(rec_en), 32'd0);
    chk("midrst rec_pkt_done", 32'(rec_pkt_done), 32'd0);
    chk("midrst rec_data", rec_data, 32'd0);
    chk("midrst rec_byte_num", 32'(rec_byte_num), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst strobes", got_done + got_w.size(), 0);
    clear_got();
    build(vecs[9]);
    drive(fq.size(), 1'b1);
    chk("post-reset nwords", got_w.size(), 0);
    chk("post-reset done", got_done, 1);
    chk("post-reset done_with_en", 32'(done_with_en), 32'd0);
    chk("post-reset byte_num", 32'(rec_byte_num), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
